// File: rtl/service_gate_sequencer.sv
// service_gate_sequencer: replays one latched register-transfer request as registered CT/RT/WT gate strobes
module service_gate_sequencer #(
  parameter int NREG   = 8,
  parameter int NSCA   = 8,
  parameter int ADDR_W = 3,
  parameter int G_IDX  = 2
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NREG-1:0]   req_rd_sel,
  input  logic [NREG-1:0]   req_wr_sel,
  input  logic              req_sc_rd,
  input  logic              req_sc_wr,
  input  logic [ADDR_W-1:0] req_sc_addr,
  input  logic              req_inh,
  input  logic              req_ci,
  input  logic              req_ci_clr,
  output logic [NREG-1:0]   clr_gate,
  output logic [NREG-1:0]   rd_gate_n,
  output logic [NREG-1:0]   wr_gate_n,
  output logic [NSCA-1:0]   sc_rd_gate_n,
  output logic [NSCA-1:0]   sc_wr_gate_n,
  output logic [NREG-1:0]   mon_wr,
  output logic              ci01_n,
  output logic              err_conflict
);
  typedef enum logic [1:0] {IDLE, CT, RT, WT} state_t;
  localparam logic [NREG-1:0] G_MASK = NREG'(1) << G_IDX;
  state_t state, nxt;
  logic [NREG-1:0] rd_sel, wr_sel;
  logic [ADDR_W-1:0] sc_addr;
  logic sc_rd, sc_wr, inh, ciff, accept, conflict;
  logic [NSCA-1:0] sc_dec;
  assign req_ready = (state == IDLE || state == WT) && !SIM_RST;
  assign accept = req_valid && req_ready;
  assign conflict = ($countones(rd_sel) + int'(sc_rd)) > 1;
  assign mon_wr = ~wr_gate_n;
  assign ci01_n = ~ciff;
  genvar a;
  for (a = 0; a < NSCA; a++) begin : g_dec
    assign sc_dec[a] = sc_addr == ADDR_W'(a);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? CT : IDLE;
      CT:   nxt = RT;
      RT:   nxt = WT;
      WT:   nxt = accept ? CT : IDLE;
    endcase
  end
  // CT strobes load straight from the request on the accepting edge; RT/WT use the latched copy
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state        <= IDLE;
      ciff         <= 1'b0;
      clr_gate     <= '0;
      rd_gate_n    <= '1;
      wr_gate_n    <= '1;
      sc_rd_gate_n <= '1;
      sc_wr_gate_n <= '1;
      err_conflict <= 1'b0;
    end else begin
      state        <= nxt;
      clr_gate     <= accept ? req_wr_sel & ~(req_inh ? G_MASK : '0) : '0;
      rd_gate_n    <= (state == CT && !conflict) ? ~rd_sel : '1;
      sc_rd_gate_n <= (state == CT && !conflict && sc_rd) ? ~sc_dec : '1;
      err_conflict <= state == CT && conflict;
      wr_gate_n    <= state == RT ? ~(wr_sel & ~(inh ? G_MASK : '0)) : '1;
      sc_wr_gate_n <= (state == RT && sc_wr) ? ~sc_dec : '1;
      if (accept) begin
        rd_sel  <= req_rd_sel;
        wr_sel  <= req_wr_sel;
        sc_rd   <= req_sc_rd;
        sc_wr   <= req_sc_wr;
        sc_addr <= req_sc_addr;
        inh     <= req_inh;
        ciff    <= req_ci ? 1'b1 : req_ci_clr ? 1'b0 : ciff;
      end
    end
  end
endmodule

// File: tb/tb_service_gate_sequencer.sv
// tb_service_gate_sequencer: directed then random requests checked against a per-cycle expectation schedule
module tb_service_gate_sequencer;
  localparam int N = 2000;
  logic clk = 0, rst = 1;
  logic valid = 0, sc_rd = 0, sc_wr = 0, inh = 0, ci = 0, ci_clr = 0;
  logic [7:0] rd_sel = 0, wr_sel = 0;
  logic [2:0] addr = 0;
  logic ready, ci01_n, err;
  logic [7:0] clr_g, rd_n, wr_n, scr_n, scw_n, mon;
  logic [7:0] e_clr [N], e_rd [N], e_wr [N], e_scr [N], e_scw [N];
  logic e_err [N];
  logic e_ci;
  int cyc = 0, last = -100, tests = 0, fails = 0;

  always #5 clk = ~clk;

  service_gate_sequencer dut (
    .SIM_CLK(clk), .SIM_RST(rst), .req_valid(valid), .req_ready(ready),
    .req_rd_sel(rd_sel), .req_wr_sel(wr_sel), .req_sc_rd(sc_rd), .req_sc_wr(sc_wr),
    .req_sc_addr(addr), .req_inh(inh), .req_ci(ci), .req_ci_clr(ci_clr),
    .clr_gate(clr_g), .rd_gate_n(rd_n), .wr_gate_n(wr_n), .sc_rd_gate_n(scr_n),
    .sc_wr_gate_n(scw_n), .mon_wr(mon), .ci01_n(ci01_n), .err_conflict(err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_at(input int k);
    e_clr[k] = 8'h00; e_rd[k] = 8'hFF; e_wr[k] = 8'hFF;
    e_scr[k] = 8'hFF; e_scw[k] = 8'hFF; e_err[k] = 1'b0;
  endtask

  // One cycle: check outputs due now, drive a new request, predict its effect on later cycles
  task automatic step(input logic v, input logic [7:0] rd, input logic [7:0] wr,
                      input logic sr, input logic sw, input logic [2:0] ad,
                      input logic ih, input logic c1, input logic cc, input logic r);
    logic acc, conf;
    logic [7:0] g, one;
    @(negedge clk);
    check("clr_gate", clr_g, e_clr[cyc]);
    check("rd_gate_n", rd_n, e_rd[cyc]);
    check("wr_gate_n", wr_n, e_wr[cyc]);
    check("sc_rd_gate_n", scr_n, e_scr[cyc]);
    check("sc_wr_gate_n", scw_n, e_scw[cyc]);
    check("mon_wr", mon, ~e_wr[cyc]);
    check("err_conflict", {7'b0, err}, {7'b0, e_err[cyc]});
    check("ci01_n", {7'b0, ci01_n}, {7'b0, ~e_ci});
    valid = v; rd_sel = rd; wr_sel = wr; sc_rd = sr; sc_wr = sw;
    addr = ad; inh = ih; ci = c1; ci_clr = cc; rst = r;
    #1;
    acc = !r && (cyc - last >= 3);
    check("req_ready", {7'b0, ready}, {7'b0, acc});
    acc = acc && v;
    if (r) begin
      last = -100; e_ci = 1'b0;
      for (int k = 1; k <= 3; k++) idle_at(cyc + k);
    end else if (acc) begin
      last = cyc;
      g = ih ? 8'h04 : 8'h00;
      one = 8'h01 << ad;
      conf = ($countones(rd) + int'(sr)) > 1;
      e_clr[cyc+1] = wr & ~g;
      e_rd[cyc+2]  = conf ? 8'hFF : ~rd;
      e_scr[cyc+2] = (conf || !sr) ? 8'hFF : ~one;
      e_err[cyc+2] = conf;
      e_wr[cyc+3]  = ~(wr & ~g);
      e_scw[cyc+3] = sw ? ~one : 8'hFF;
      if (c1) e_ci = 1'b1;
      else if (cc) e_ci = 1'b0;
    end
    cyc++;
  endtask

  task automatic req(input logic [7:0] rd, input logic [7:0] wr, input logic sr, input logic sw,
                     input logic [2:0] ad, input logic ih, input logic c1, input logic cc);
    step(1, rd, wr, sr, sw, ad, ih, c1, cc, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) idle_at(k);
    e_ci = 1'b0;
    @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    req(8'h01, 8'h08, 0, 0, 0, 0, 0, 0);
    idle(5);
    for (int i = 0; i < 9; i++) req(8'h10 << (i % 3), 8'h20 + 8'(i), i[0], !i[0], 3'(i), 0, 0, 0);
    idle(4);
    req(8'h03, 8'h00, 0, 0, 0, 0, 0, 0);
    idle(3);
    req(8'h01, 8'h40, 1, 0, 3'd4, 0, 0, 0);
    idle(3);
    req(8'h00, 8'h05, 0, 0, 0, 1, 0, 0);
    idle(3);
    req(8'h00, 8'h05, 0, 1, 3'd5, 1, 0, 0);
    idle(3);
    req(8'h00, 8'h00, 1, 0, 3'd6, 0, 0, 0);
    idle(3);
    req(8'h00, 8'h01, 0, 0, 0, 0, 1, 0);
    idle(3);
    req(8'h00, 8'h02, 0, 0, 0, 0, 0, 0);
    idle(3);
    req(8'h00, 8'h04, 0, 0, 0, 0, 0, 1);
    idle(3);
    req(8'h00, 8'h08, 0, 0, 0, 0, 1, 1);
    idle(3);
    req(8'h02, 8'hFF, 1, 1, 3'd1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    step(1, 8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] rd;
      int sel;
      sel = int'($urandom_range(0, 3));
      rd = sel == 0 ? 8'h00 : sel == 3 ? 8'($urandom) : 8'h01 << $urandom_range(0, 7);
      step($urandom_range(0, 9) < 6, rd, 8'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 49) == 0);
    end
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
